// File: rtl/line_fetch_ctrl_if.sv
// SDRAM read port and line-buffer write port of the row fetcher.
// master: the fetch controller; slave: the arbiter / buffer side.
interface line_fetch_ctrl_if;
    // SDRAM arbiter side
    logic        read_req;
    logic [20:0] address;
    logic        read_grant;
    logic        data_valid;
    logic [15:0] data;
    // Ping-pong line buffer write side
    logic        buf_we;
    logic        buf_bank;
    logic [9:0]  buf_waddr;
    logic [11:0] buf_wdata;

    modport master (
        output read_req, address, buf_we, buf_bank, buf_waddr, buf_wdata,
        input  read_grant, data_valid, data
    );

    modport slave (
        input  read_req, address, buf_we, buf_bank, buf_waddr, buf_wdata,
        output read_grant, data_valid, data
    );
endinterface

// File: rtl/line_fetch_ctrl.sv
// Row fetch controller: pulls one row of RGB444 pixels for the selected
// scene from SDRAM in fixed-length bursts and writes them into the
// ping-pong line buffer bank currently owned by the fetcher.
module line_fetch_ctrl #(
    parameter int LINE_WORDS = 640,
    parameter int ROWS       = 480,
    parameter int BURST_LEN  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        game_state,
    input  logic              fetch_start,
    input  logic [8:0]        fetch_row,
    line_fetch_ctrl_if.master bus,
    output logic              busy,
    output logic              fetch_done,
    output logic              err
);

    localparam int BEAT_W = $clog2(BURST_LEN + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t              state_reg;
    logic [BEAT_W-1:0]   beat_cnt_reg;
    logic [9:0]          col_reg;
    logic                read_req_reg;
    logic [20:0]         address_reg;
    logic                buf_we_reg;
    logic                buf_bank_reg;
    logic [9:0]          buf_waddr_reg;
    logic [11:0]         buf_wdata_reg;
    logic                busy_reg;
    logic                fetch_done_reg;
    logic                err_reg;

    // Row start address. The scene and row only matter at acceptance, so
    // they are folded straight into the address register rather than kept
    // as separate copies; later bursts just add BURST_LEN to it.
    logic [20:0] start_addr;
    logic        row_ok;
    logic        last_beat;
    logic [10:0] col_plus_one;

    assign start_addr   = 21'(game_state) * 21'(ROWS * LINE_WORDS)
                        + 21'(fetch_row)  * 21'(LINE_WORDS);
    assign row_ok       = ({23'd0, fetch_row} < 32'(ROWS));
    assign last_beat    = (beat_cnt_reg == BEAT_W'(BURST_LEN - 1));
    assign col_plus_one = {1'b0, col_reg} + 11'd1;

    // Upper data bits carry no pixel information.
    logic unused_data_hi;
    assign unused_data_hi = ^bus.data[15:12];

    // Fetch sequencer: request a burst, collect its beats, repeat until the
    // row is complete, then hand the bank over to the display side.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= ST_IDLE;
            beat_cnt_reg   <= '0;
            col_reg        <= '0;
            read_req_reg   <= 1'b0;
            address_reg    <= '0;
            buf_we_reg     <= 1'b0;
            buf_bank_reg   <= 1'b0;
            buf_waddr_reg  <= '0;
            buf_wdata_reg  <= '0;
            busy_reg       <= 1'b0;
            fetch_done_reg <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            buf_we_reg     <= 1'b0;
            fetch_done_reg <= 1'b0;

            // A new request while a row is in flight is an overrun; the
            // current row carries on untouched.
            if (fetch_start && (state_reg != ST_IDLE)) begin
                err_reg <= 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (fetch_start) begin
                        if (row_ok) begin
                            state_reg    <= ST_REQ;
                            col_reg      <= '0;
                            beat_cnt_reg <= '0;
                            address_reg  <= start_addr;
                            read_req_reg <= 1'b1;
                            busy_reg     <= 1'b1;
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end
                end

                ST_REQ: begin
                    // Beats cannot arrive before the grant has been seen,
                    // so data_valid is deliberately not looked at here.
                    if (bus.read_grant) begin
                        state_reg    <= ST_DATA;
                        read_req_reg <= 1'b0;
                    end
                end

                ST_DATA: begin
                    if (bus.data_valid) begin
                        buf_we_reg    <= 1'b1;
                        buf_waddr_reg <= col_reg;
                        buf_wdata_reg <= bus.data[11:0];
                        col_reg       <= col_reg + 10'd1;
                        if (last_beat) begin
                            beat_cnt_reg <= '0;
                            if (col_plus_one < 11'(LINE_WORDS)) begin
                                state_reg    <= ST_REQ;
                                read_req_reg <= 1'b1;
                                address_reg  <= address_reg + 21'(BURST_LEN);
                            end else begin
                                state_reg      <= ST_DONE;
                                fetch_done_reg <= 1'b1;
                            end
                        end else begin
                            beat_cnt_reg <= beat_cnt_reg + BEAT_W'(1);
                        end
                    end
                end

                ST_DONE: begin
                    state_reg    <= ST_IDLE;
                    busy_reg     <= 1'b0;
                    buf_bank_reg <= ~buf_bank_reg;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.read_req  = read_req_reg;
    assign bus.address   = address_reg;
    assign bus.buf_we    = buf_we_reg;
    assign bus.buf_bank  = buf_bank_reg;
    assign bus.buf_waddr = buf_waddr_reg;
    assign bus.buf_wdata = buf_wdata_reg;
    assign busy          = busy_reg;
    assign fetch_done    = fetch_done_reg;
    assign err           = err_reg;

endmodule

// File: tb/tb_line_fetch_ctrl.sv
// Testbench for line_fetch_ctrl: an SDRAM agent serves bursts from a
// hashed scene memory, a scoreboard holds the expected row contents, and
// a monitor checks every line-buffer write and fetch_done as it appears.
module tb_line_fetch_ctrl;

    localparam int LINE_WORDS = 640;
    localparam int ROWS       = 480;
    localparam int BURST_LEN  = 8;
    localparam int BURSTS     = LINE_WORDS / BURST_LEN;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] game_state = 2'd0;
    logic       fetch_start = 1'b0;
    logic [8:0] fetch_row = 9'd0;
    logic       busy;
    logic       fetch_done;
    logic       err;

    line_fetch_ctrl_if bus_i ();

    line_fetch_ctrl #(
        .LINE_WORDS (LINE_WORDS),
        .ROWS       (ROWS),
        .BURST_LEN  (BURST_LEN)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .game_state  (game_state),
        .fetch_start (fetch_start),
        .fetch_row   (fetch_row),
        .bus         (bus_i),
        .busy        (busy),
        .fetch_done  (fetch_done),
        .err         (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int waddr;
        int wdata;
        int bank;
    } wr_t;

    wr_t exp_wr[$];
    int  exp_addr[$];
    int  exp_done[$];

    int errors = 0;
    int checks = 0;
    int wr_seen = 0;
    int grant_cnt = 0;
    int last_grant_addr = 0;
    int bank_model = 0;
    int gmax = 0;
    int vmax = 0;
    bit junk_en = 1'b0;
    bit agent_hold = 1'b1;

    // Scene memory contents: a fixed hash of the word address.
    function automatic logic [15:0] mem_word(input int a);
        logic [31:0] h;
        h = 32'(a) * 32'd2654435761;
        return h[27:12];
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input int act);
        checks++;
        errors++;
        $display("FAIL %s: got %0d expected none", name, act);
    endtask

    // Line-buffer monitor / scoreboard consumer
    initial begin
        wr_t e;
        int  b;
        forever begin
            @(negedge clk);
            if (bus_i.buf_we) begin
                wr_seen++;
                if (exp_wr.size() == 0) begin
                    flag("unexpected_buf_we", int'(bus_i.buf_waddr));
                end else begin
                    e = exp_wr.pop_front();
                    check("buf_waddr", int'(bus_i.buf_waddr), e.waddr);
                    check("buf_wdata", int'(bus_i.buf_wdata), e.wdata);
                    check("buf_bank", int'(bus_i.buf_bank), e.bank);
                    $display("write col=%0d data=%03h bank=%0d",
                             bus_i.buf_waddr, bus_i.buf_wdata, bus_i.buf_bank);
                end
            end
            if (fetch_done) begin
                if (exp_done.size() == 0) begin
                    flag("unexpected_fetch_done", 1);
                end else begin
                    b = exp_done.pop_front();
                    check("done_bank", int'(bus_i.buf_bank), b);
                    check("done_with_last_we", int'(bus_i.buf_we), 1);
                    check("writes_left_at_done", exp_wr.size(), 0);
                    $display("fetch_done bank=%0d", bus_i.buf_bank);
                end
            end
        end
    end

    // SDRAM agent: grants after a random delay, then streams BURST_LEN beats
    // with random gaps; sprinkles junk data_valid where it must be ignored.
    initial begin
        int phase;
        int wait_cnt;
        int beat;
        int gap;
        int cur_addr;
        bit step;
        phase = 0; wait_cnt = 0; beat = 0; gap = 0; cur_addr = 0;
        bus_i.read_grant = 1'b0;
        bus_i.data_valid = 1'b0;
        bus_i.data = 16'd0;
        forever begin
            @(negedge clk);
            bus_i.read_grant = 1'b0;
            bus_i.data_valid = 1'b0;
            bus_i.data = 16'($urandom);
            step = 1'b0;
            if (agent_hold) begin
                phase = 0;
                bus_i.data_valid = junk_en && ($urandom_range(0, 1) == 1);
            end else if (phase == 2) begin
                check("read_req_low_in_data", int'(bus_i.read_req), 0);
                if (gap == 0) begin
                    bus_i.data_valid = 1'b1;
                    bus_i.data = mem_word(cur_addr + beat);
                    beat++;
                    gap = $urandom_range(0, vmax);
                    if (beat == BURST_LEN) phase = 0;
                end else begin
                    gap--;
                end
            end else if (phase == 1) begin
                check("read_req_held", int'(bus_i.read_req), 1);
                check("address_stable", int'(bus_i.address), cur_addr);
                step = 1'b1;
            end else if (bus_i.read_req) begin
                if (exp_addr.size() == 0) begin
                    flag("unexpected_read_req", int'(bus_i.address));
                end else begin
                    check("req_address", int'(bus_i.address), exp_addr.pop_front());
                end
                cur_addr = int'(bus_i.address);
                wait_cnt = $urandom_range(0, gmax);
                phase = 1;
                step = 1'b1;
            end else begin
                bus_i.data_valid = junk_en && ($urandom_range(0, 3) == 0);
            end
            if (step) begin
                if (wait_cnt == 0) begin
                    bus_i.read_grant = 1'b1;
                    bus_i.data_valid = junk_en && ($urandom_range(0, 1) == 1);
                    grant_cnt++;
                    last_grant_addr = cur_addr;
                    $display("grant address=%0d", cur_addr);
                    phase = 2;
                    beat = 0;
                    gap = $urandom_range(0, vmax);
                end else begin
                    wait_cnt--;
                    bus_i.data_valid = junk_en && ($urandom_range(0, 2) == 0);
                end
            end
        end
    end

    // Issue one fetch_start pulse and record what the row should produce.
    task automatic start_row(input int gs, input int row);
        int          base;
        wr_t         w;
        logic [15:0] mw;
        game_state  = 2'(gs);
        fetch_row   = 9'(row);
        fetch_start = 1'b1;
        grant_cnt   = 0;
        if (row < ROWS) begin
            base = gs * ROWS * LINE_WORDS + row * LINE_WORDS;
            for (int k = 0; k < BURSTS; k++) exp_addr.push_back(base + k * BURST_LEN);
            for (int c = 0; c < LINE_WORDS; c++) begin
                mw = mem_word(base + c);
                w.waddr = c;
                w.wdata = int'(mw[11:0]);
                w.bank  = bank_model;
                exp_wr.push_back(w);
            end
            exp_done.push_back(bank_model);
        end
        $display("fetch_start state=%0d row=%0d", gs, row);
        @(posedge clk);
        #2;
        fetch_start = 1'b0;
    endtask

    // Wait (bounded) for the row to finish, then check the bank hand-over.
    task automatic finish_row(input string tag);
        int n;
        n = 0;
        while (exp_done.size() != 0 && n < 20000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 20000) flag({tag, "_timeout"}, n);
        #2;
        check({tag, "_busy_after"}, int'(busy), 0);
        check({tag, "_bank_toggled"}, int'(bus_i.buf_bank), 1 - bank_model);
        check({tag, "_grants"}, grant_cnt, BURSTS);
        check({tag, "_writes_left"}, exp_wr.size() + exp_addr.size(), 0);
        bank_model = 1 - bank_model;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_read_req"}, int'(bus_i.read_req), 0);
        check({tag, "_address"}, int'(bus_i.address), 0);
        check({tag, "_buf_we"}, int'(bus_i.buf_we), 0);
        check({tag, "_buf_bank"}, int'(bus_i.buf_bank), 0);
        check({tag, "_buf_waddr"}, int'(bus_i.buf_waddr), 0);
        check({tag, "_buf_wdata"}, int'(bus_i.buf_wdata), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_fetch_done"}, int'(fetch_done), 0);
        check({tag, "_err"}, int'(err), 0);
    endtask

    // Main sequence
    initial begin
        int target;
        int n;
        repeat (2) @(posedge clk);
        #2;
        check_all_zero("reset");
        reset = 1'b1;
        agent_hold = 1'b0;

        // First row: immediate grants, back-to-back beats
        gmax = 0; vmax = 0; junk_en = 1'b0;
        start_row(2, 5);
        check("first_read_req", int'(bus_i.read_req), 1);
        check("first_address", int'(bus_i.address), 617600);
        check("first_busy", int'(busy), 1);
        finish_row("row_2_5");

        start_row(0, 0);
        finish_row("row_0_0");

        // Random grant delays, beat gaps and ignored junk beats
        gmax = 10; vmax = 3; junk_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start_row(int'($urandom_range(0, 3)), int'($urandom_range(0, ROWS - 1)));
            finish_row("rand_row");
        end
        check("err_clear_before_overrun", int'(err), 0);

        // Overrun fetch_start mid-row
        start_row(1, 200);
        repeat (60) @(posedge clk);
        #2;
        fetch_row   = 9'($urandom_range(0, ROWS - 1));
        fetch_start = 1'b1;
        @(posedge clk);
        #2;
        fetch_start = 1'b0;
        check("err_after_overrun", int'(err), 1);
        check("busy_after_overrun", int'(busy), 1);
        finish_row("overrun_row");

        // Out-of-range row while idle
        start_row(0, ROWS);
        repeat (10) @(posedge clk);
        #2;
        check("bad_row_busy", int'(busy), 0);
        check("bad_row_read_req", int'(bus_i.read_req), 0);
        check("bad_row_err", int'(err), 1);

        // Largest address: scene 3, last row
        start_row(3, ROWS - 1);
        finish_row("row_3_479");
        check("last_burst_address", last_grant_addr, 1228792);
        check("err_still_set", int'(err), 1);

        // Reset in the middle of a burst
        start_row(1, 100);
        target = wr_seen + 100;
        n = 0;
        while (wr_seen < target && n < 5000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 5000) flag("mid_row_wait_timeout", n);
        #2;
        reset = 1'b0;
        agent_hold = 1'b1;
        @(posedge clk);
        #2;
        check_all_zero("midreset");
        exp_wr.delete();
        exp_addr.delete();
        exp_done.delete();
        bank_model = 0;
        reset = 1'b1;
        repeat (20) @(posedge clk);
        #2;
        check("post_reset_busy", int'(busy), 0);
        agent_hold = 1'b0;

        // Recovery row after reset
        start_row(0, ROWS - 1);
        finish_row("recovery_row");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
